// File: rtl/mul_result_queue.sv
// Result stage behind the 64x64 signed multiplier.
// Formats LO/HI/SAT and buffers results for writeback.
module mul_result_queue #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 5,
    parameter int DEPTH  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*DATA_W-1:0] prod,
    input  logic                ovf,
    input  logic [1:0]          op,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_ovf,
    output logic                ovf_sticky,
    input  logic                clr_sticky
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] OP_HI  = 2'b01;
    localparam logic [1:0] OP_SAT = 2'b10;

    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [TAG_W-1:0]  mem_tag  [DEPTH];
    logic              mem_ovf  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              live;
    logic [DATA_W-1:0] fmt_data;
    logic              push;
    logic              pop;

    // in_ready comes only from registered state; live holds it low in reset
    assign in_ready  = live && (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Result formatting from the raw product; op=11 falls through to LO
    always_comb begin
        fmt_data = prod[DATA_W-1:0];
        case (op)
            OP_HI:  fmt_data = prod[2*DATA_W-1:DATA_W];
            OP_SAT: begin
                if (ovf)
                    fmt_data = prod[2*DATA_W-1] ? SAT_MIN : SAT_MAX;
            end
            default: fmt_data = prod[DATA_W-1:0];
        endcase
    end

    // Entry storage, written on push only; never reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= fmt_data;
            mem_tag[wr_ptr]  <= in_tag;
            mem_ovf[wr_ptr]  <= ovf;
        end
    end

    // Pointers, occupancy and the post-reset ready flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            live   <= 1'b0;
        end else begin
            live <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    // Sticky overflow: a new overflow beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_sticky <= 1'b0;
        else if (push && ovf)
            ovf_sticky <= 1'b1;
        else if (clr_sticky)
            ovf_sticky <= 1'b0;
    end

    // Head entry drives the outputs; zeros when empty
    always_comb begin
        out_data = '0;
        out_tag  = '0;
        out_ovf  = 1'b0;
        if (out_valid) begin
            out_data = mem_data[rd_ptr];
            out_tag  = mem_tag[rd_ptr];
            out_ovf  = mem_ovf[rd_ptr];
        end
    end

endmodule
